// File: rtl/usb_spi_pkg.sv
// Shared definitions for the MAX3421E SPI link: FSM states, command byte
// layout and the register map used by both ends of the link.
package usb_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } spi_state_t;

    // Command byte layout: {addr[7:3], unused[2], dir[1], ackstat[0]}
    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_DIR_BIT  = 1;
    localparam int CMD_ACK_BIT  = 0;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // MAX3421E register map (subset used by usb_controller)
    localparam logic [REG_ADDR_W-1:0] REG_RCVFIFO  = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_SNDFIFO  = 5'd2;
    localparam logic [REG_ADDR_W-1:0] REG_USBIRQ   = 5'd13;
    localparam logic [REG_ADDR_W-1:0] REG_USBIEN   = 5'd14;
    localparam logic [REG_ADDR_W-1:0] REG_USBCTL   = 5'd15;
    localparam logic [REG_ADDR_W-1:0] REG_CPUCTL   = 5'd16;
    localparam logic [REG_ADDR_W-1:0] REG_PINCTL   = 5'd17;
    localparam logic [REG_ADDR_W-1:0] REG_REVISION = 5'd18;
    localparam logic [REG_ADDR_W-1:0] REG_HIRQ     = 5'd25;
    localparam logic [REG_ADDR_W-1:0] REG_MODE     = 5'd27;
    localparam logic [REG_ADDR_W-1:0] REG_HCTL     = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_HXFR     = 5'd30;
    localparam logic [REG_ADDR_W-1:0] REG_HRSL     = 5'd31;

    // Extract the register address from a command byte.
    function automatic logic [REG_ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise and fall strobes derived from the synchronized level.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic n_rst_in,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out,
    output logic fall_out
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the pin through the synchronizer and keep one cycle of history.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, which is what makes the chain a chain.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    assign rise_out = sync_out & ~prev;
    assign fall_out = ~sync_out & prev;

endmodule

// File: rtl/max3421_spi_responder.sv
// SPI responder standing in for the MAX3421E: decodes the command byte,
// shifts out the status byte, and serves a 32 x 8 register file.
module max3421_spi_responder
    import usb_spi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RO_MASK     = 32'h0000_0000
) (
    input  logic                  clk_in,
    input  logic                  n_rst_in,
    input  logic                  sclk_in,
    input  logic                  n_ss_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe_out,
    input  logic [7:0]            status_in,
    input  logic                  loc_we_in,
    input  logic [REG_ADDR_W-1:0] loc_addr_in,
    input  logic [7:0]            loc_data_in,
    output logic                  wr_valid_out,
    output logic [REG_ADDR_W-1:0] wr_addr_out,
    output logic [7:0]            wr_data_out,
    output logic                  rd_valid_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic                  busy_out
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_in   (clk_in),
        .n_rst_in (n_rst_in),
        .async_in (sclk_in),
        .sync_out (sclk_level_unused),
        .rise_out (sclk_rise),
        .fall_out (sclk_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_in   (clk_in),
        .n_rst_in (n_rst_in),
        .async_in (n_ss_in),
        .sync_out (ss_level),
        .rise_out (ss_rise),
        .fall_out (ss_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_in   (clk_in),
        .n_rst_in (n_rst_in),
        .async_in (mosi_in),
        .sync_out (mosi_level),
        .rise_out (mosi_rise_unused),
        .fall_out (mosi_fall_unused)
    );

    spi_state_t            state;
    logic                  armed;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift_in;
    logic [7:0]            shift_out;
    logic [REG_ADDR_W-1:0] addr;
    logic                  ackstat_unused;
    logic [7:0]            regs [NUM_REGS];

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       spi_commit;

    // The byte as it stands including the bit being sampled on this rise.
    assign rx_byte    = {shift_in[6:0], mosi_level};
    assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
    assign spi_commit = (state == WR) && byte_done && !ss_rise && !RO_MASK[addr];
    assign busy_out   = (state != IDLE);

    // Transaction FSM: select handling, bit shifting and byte-level actions.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state          <= IDLE;
            armed          <= 1'b0;
            bit_cnt        <= 3'd0;
            shift_in       <= 8'h00;
            shift_out      <= 8'h00;
            addr           <= '0;
            ackstat_unused <= 1'b0;
            miso_out       <= 1'b0;
            miso_oe_out    <= 1'b0;
            wr_valid_out   <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= 8'h00;
            rd_valid_out   <= 1'b0;
            rd_addr_out    <= '0;
        end else begin
            wr_valid_out <= 1'b0;
            rd_valid_out <= 1'b0;
            // A select held low through reset must not start a transaction.
            if (ss_level) armed <= 1'b1;

            if (ss_rise) begin
                state       <= IDLE;
                miso_oe_out <= 1'b0;
                miso_out    <= 1'b0;
                bit_cnt     <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall && armed) begin
                            state       <= CMD;
                            shift_out   <= status_in;
                            miso_out    <= status_in[7];
                            miso_oe_out <= 1'b1;
                            bit_cnt     <= 3'd0;
                        end
                    end
                    default: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    CMD: begin
                                        addr           <= cmd_addr(rx_byte);
                                        ackstat_unused <= rx_byte[CMD_ACK_BIT];
                                        if (rx_byte[CMD_DIR_BIT]) begin
                                            state     <= WR;
                                            shift_out <= 8'h00;
                                        end else begin
                                            state     <= RD;
                                            shift_out <= regs[cmd_addr(rx_byte)];
                                        end
                                    end
                                    WR: begin
                                        wr_valid_out <= 1'b1;
                                        wr_addr_out  <= addr;
                                        wr_data_out  <= rx_byte;
                                    end
                                    RD: begin
                                        rd_valid_out <= 1'b1;
                                        rd_addr_out  <= addr;
                                        shift_out    <= regs[addr];
                                    end
                                    default: ;
                                endcase
                            end
                        end else if (sclk_fall) begin
                            // First fall of a byte shows the freshly loaded MSB;
                            // later falls advance to the next bit.
                            if (bit_cnt == 3'd0) begin
                                miso_out <= shift_out[7];
                            end else begin
                                miso_out  <= shift_out[6];
                                shift_out <= {shift_out[6:0], 1'b0};
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Register file: local writes first, SPI commit last so SPI wins on a tie.
    // NOTE: the register file is reset explicitly because software expects
    // every register to read zero after reset; this forces flops, not RAM.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            if (loc_we_in) regs[loc_addr_in] <= loc_data_in;
            // NOTE: of two non-blocking writes to one element in a block,
            // the later statement takes effect, giving SPI priority.
            if (spi_commit) regs[addr] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_max3421_spi_responder.sv
// Self-checking bench for max3421_spi_responder: directed scenarios plus
// randomized transactions against a register-array reference model.
module tb_max3421_spi_responder;

    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] RO_MASK     = 32'h0004_0008;

    logic       clk_in = 1'b0;
    logic       n_rst_in;
    logic       sclk_in;
    logic       n_ss_in;
    logic       mosi_in;
    logic       miso_out;
    logic       miso_oe_out;
    logic [7:0] status_in;
    logic       loc_we_in;
    logic [4:0] loc_addr_in;
    logic [7:0] loc_data_in;
    logic       wr_valid_out;
    logic [4:0] wr_addr_out;
    logic [7:0] wr_data_out;
    logic       rd_valid_out;
    logic [4:0] rd_addr_out;
    logic       busy_out;

    max3421_spi_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .RO_MASK    (RO_MASK)
    ) dut (
        .clk_in       (clk_in),
        .n_rst_in     (n_rst_in),
        .sclk_in      (sclk_in),
        .n_ss_in      (n_ss_in),
        .mosi_in      (mosi_in),
        .miso_out     (miso_out),
        .miso_oe_out  (miso_oe_out),
        .status_in    (status_in),
        .loc_we_in    (loc_we_in),
        .loc_addr_in  (loc_addr_in),
        .loc_data_in  (loc_data_in),
        .wr_valid_out (wr_valid_out),
        .wr_addr_out  (wr_addr_out),
        .wr_data_out  (wr_data_out),
        .rd_valid_out (rd_valid_out),
        .rd_addr_out  (rd_addr_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int         checks   = 0;
    int         failures = 0;
    int         half     = 8;
    logic [7:0] model  [32];
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [12:0] wr_q [$];
    logic [4:0]  rd_q [$];
    logic        sel_ok;

    // Record every commit/read pulse seen by the initiator side.
    always @(negedge clk_in) begin
        if (wr_valid_out) wr_q.push_back({wr_addr_out, wr_data_out});
        if (rd_valid_out) rd_q.push_back(rd_addr_out);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi_in = b;
        tick(half);
        sclk_in = 1'b1;
        m = miso_out;
        sel_ok = sel_ok & miso_oe_out & busy_out;
        tick(half);
        sclk_in = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tb, output logic [7:0] rb);
        for (int i = 7; i >= 0; i--) begin
            logic m;
            spi_bit(tb[i], m);
            rb[i] = m;
        end
    endtask

    task automatic deselect();
        tick(half);
        n_ss_in = 1'b1;
        tick(2 * half + 6);
    endtask

    task automatic spi_txn(input int n);
        logic [7:0] rb;
        sel_ok  = 1'b1;
        n_ss_in = 1'b0;
        for (int k = 0; k < n; k++) begin
            spi_byte(tx_buf[k], rb);
            rx_buf[k] = rb;
        end
        deselect();
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        loc_we_in   = 1'b1;
        loc_addr_in = a;
        loc_data_in = d;
        tick(1);
        loc_we_in   = 1'b0;
        model[a]    = d;
    endtask

    task automatic test_reset();
        tick(3);
        if ({miso_out, miso_oe_out, busy_out, wr_valid_out, rd_valid_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected 00000",
                     {miso_out, miso_oe_out, busy_out, wr_valid_out, rd_valid_out});
        end
        checks++;
        if ({wr_addr_out, wr_data_out, rd_addr_out} !== 18'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {wr_addr_out, wr_data_out, rd_addr_out});
        end
        checks++;
        n_rst_in = 1'b1;
        tick(6);
        if ({miso_oe_out, busy_out} !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected 00", {miso_oe_out, busy_out});
        end
        checks++;
    endtask

    task automatic test_read_basic();
        loc_write(5'd18, 8'h13);
        status_in = 8'hA5;
        wr_q.delete();
        rd_q.delete();
        tx_buf[0] = 8'h90;
        tx_buf[1] = 8'h00;
        spi_txn(2);
        if (rx_buf[0] !== 8'hA5) begin
            failures++;
            $display("FAIL rd_status: got %h expected a5", rx_buf[0]);
        end
        checks++;
        if (rx_buf[1] !== 8'h13) begin
            failures++;
            $display("FAIL rd_data: got %h expected 13", rx_buf[1]);
        end
        checks++;
        if (sel_ok !== 1'b1) begin
            failures++;
            $display("FAIL rd_oe_busy: got %b expected 1", sel_ok);
        end
        checks++;
        if (rd_q.size() !== 1 || wr_q.size() !== 0) begin
            failures++;
            $display("FAIL rd_pulses: got rd=%0d wr=%0d expected rd=1 wr=0", rd_q.size(), wr_q.size());
        end else if (rd_q[0] !== 5'd18) begin
            failures++;
            $display("FAIL rd_addr: got %0d expected 18", rd_q[0]);
        end
        checks++;
    endtask

    task automatic test_write_basic();
        wr_q.delete();
        rd_q.delete();
        tx_buf[0] = 8'h7A;
        tx_buf[1] = 8'h3C;
        spi_txn(2);
        model[15] = 8'h3C;
        if (wr_q.size() !== 1 || rd_q.size() !== 0) begin
            failures++;
            $display("FAIL wr_pulses: got wr=%0d rd=%0d expected wr=1 rd=0", wr_q.size(), rd_q.size());
        end else if (wr_q[0] !== {5'd15, 8'h3C}) begin
            failures++;
            $display("FAIL wr_entry: got %h expected %h", wr_q[0], {5'd15, 8'h3C});
        end
        checks++;
        status_in = 8'h5E;
        tx_buf[0] = 8'h78;
        tx_buf[1] = 8'h00;
        spi_txn(2);
        if ({rx_buf[0], rx_buf[1]} !== {8'h5E, 8'h3C}) begin
            failures++;
            $display("FAIL wr_readback: got %h expected 5e3c", {rx_buf[0], rx_buf[1]});
        end
        checks++;
    endtask

    task automatic test_multi_byte();
        logic [7:0] vals [3];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        wr_q.delete();
        rd_q.delete();
        tx_buf[0] = 8'h8A;
        for (int k = 0; k < 3; k++) tx_buf[k+1] = vals[k];
        spi_txn(4);
        model[17] = 8'h33;
        if (wr_q.size() !== 3) begin
            failures++;
            $display("FAIL multi_wr_count: got %0d expected 3", wr_q.size());
        end
        checks++;
        for (int k = 0; k < 3 && k < wr_q.size(); k++) begin
            if (wr_q[k] !== {5'd17, vals[k]}) begin
                failures++;
                $display("FAIL multi_wr_entry%0d: got %h expected %h", k, wr_q[k], {5'd17, vals[k]});
            end
            checks++;
        end
        rd_q.delete();
        tx_buf[0] = 8'h88;
        for (int k = 1; k < 4; k++) tx_buf[k] = 8'h00;
        spi_txn(4);
        for (int k = 1; k < 4; k++) begin
            if (rx_buf[k] !== 8'h33) begin
                failures++;
                $display("FAIL multi_rd_byte%0d: got %h expected 33", k, rx_buf[k]);
            end
            checks++;
        end
        if (rd_q.size() !== 3) begin
            failures++;
            $display("FAIL multi_rd_count: got %0d expected 3", rd_q.size());
        end
        checks++;
    endtask

    task automatic test_read_only();
        wr_q.delete();
        tx_buf[0] = 8'h92;
        tx_buf[1] = 8'hFF;
        spi_txn(2);
        if (wr_q.size() !== 1) begin
            failures++;
            $display("FAIL ro_pulse: got %0d pulses expected 1", wr_q.size());
        end else if (wr_q[0] !== {5'd18, 8'hFF}) begin
            failures++;
            $display("FAIL ro_entry: got %h expected %h", wr_q[0], {5'd18, 8'hFF});
        end
        checks++;
        tx_buf[0] = 8'h90;
        tx_buf[1] = 8'h00;
        spi_txn(2);
        if (rx_buf[1] !== model[18]) begin
            failures++;
            $display("FAIL ro_unchanged: got %h expected %h", rx_buf[1], model[18]);
        end
        checks++;
    endtask

    task automatic test_abort();
        logic       m;
        logic [7:0] rb;
        wr_q.delete();
        n_ss_in = 1'b0;
        spi_byte(8'h7A, rb);
        for (int i = 0; i < 4; i++) spi_bit(i[0], m);
        tick(half);
        n_ss_in = 1'b1;
        tick(SYNC_STAGES);
        if (busy_out !== 1'b1) begin
            failures++;
            $display("FAIL abort_early: busy got %b expected 1", busy_out);
        end
        checks++;
        tick(1);
        if ({miso_out, miso_oe_out, busy_out} !== 3'b000) begin
            failures++;
            $display("FAIL abort_release: got %b expected 000", {miso_out, miso_oe_out, busy_out});
        end
        checks++;
        tick(2 * half + 6);
        if (wr_q.size() !== 0) begin
            failures++;
            $display("FAIL abort_no_pulse: got %0d pulses expected 0", wr_q.size());
        end
        checks++;
        tx_buf[0] = 8'h78;
        tx_buf[1] = 8'h00;
        spi_txn(2);
        if (rx_buf[1] !== model[15]) begin
            failures++;
            $display("FAIL abort_unchanged: got %h expected %h", rx_buf[1], model[15]);
        end
        checks++;
        tx_buf[0] = 8'h7A;
        tx_buf[1] = 8'h5A;
        spi_txn(2);
        model[15] = 8'h5A;
        tx_buf[0] = 8'h78;
        spi_txn(2);
        if (rx_buf[1] !== 8'h5A) begin
            failures++;
            $display("FAIL abort_recover: got %h expected 5a", rx_buf[1]);
        end
        checks++;
    endtask

    task automatic test_reset_mid_rd();
        logic       m;
        logic [7:0] rb;
        logic       idle_ok;
        n_ss_in = 1'b0;
        spi_byte(8'h78, rb);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
        sclk_in  = 1'b1;
        tick(half);
        n_rst_in = 1'b0;
        #1;
        if ({miso_out, miso_oe_out, busy_out, wr_valid_out, rd_valid_out} !== 5'b0) begin
            failures++;
            $display("FAIL midrd_reset: got %b expected 00000",
                     {miso_out, miso_oe_out, busy_out, wr_valid_out, rd_valid_out});
        end
        checks++;
        for (int a = 0; a < 32; a++) model[a] = 8'h00;
        sclk_in = 1'b0;
        tick(3);
        n_rst_in = 1'b1;
        wr_q.delete();
        rd_q.delete();
        idle_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'($urandom_range(0, 1)), m);
            idle_ok = idle_ok & ~miso_oe_out & ~busy_out;
        end
        if (idle_ok !== 1'b1 || wr_q.size() !== 0 || rd_q.size() !== 0) begin
            failures++;
            $display("FAIL midrd_ignored: idle=%b wr=%0d rd=%0d expected idle=1 wr=0 rd=0",
                     idle_ok, wr_q.size(), rd_q.size());
        end
        checks++;
        n_ss_in = 1'b1;
        tick(10);
        status_in = 8'hC7;
        tx_buf[0] = 8'h78;
        tx_buf[1] = 8'h00;
        spi_txn(2);
        if ({rx_buf[0], rx_buf[1]} !== {8'hC7, 8'h00}) begin
            failures++;
            $display("FAIL midrd_rearm: got %h expected c700", {rx_buf[0], rx_buf[1]});
        end
        checks++;
    endtask

    task automatic spi_write_collide(input logic [4:0] sa, input logic [7:0] sd,
                                     input logic [4:0] la, input logic [7:0] ld,
                                     output logic pulse_early, output logic pulse_seen);
        logic       m;
        logic [7:0] rb;
        n_ss_in = 1'b0;
        spi_byte({sa, 3'b010}, rb);
        for (int i = 7; i >= 1; i--) spi_bit(sd[i], m);
        mosi_in = sd[0];
        tick(half);
        sclk_in = 1'b1;
        tick(SYNC_STAGES);
        pulse_early = wr_valid_out;
        loc_we_in   = 1'b1;
        loc_addr_in = la;
        loc_data_in = ld;
        tick(1);
        loc_we_in  = 1'b0;
        pulse_seen = wr_valid_out;
        tick(half - SYNC_STAGES - 1);
        sclk_in = 1'b0;
        deselect();
    endtask

    task automatic test_collision();
        logic early, seen;
        half = 8;
        spi_write_collide(5'd20, 8'h5C, 5'd20, 8'hC3, early, seen);
        model[20] = 8'h5C;
        if ({early, seen} !== 2'b01) begin
            failures++;
            $display("FAIL coll_pulse_timing: got %b expected 01", {early, seen});
        end
        checks++;
        tx_buf[0] = {5'd20, 3'b000};
        tx_buf[1] = 8'h00;
        spi_txn(2);
        if (rx_buf[1] !== 8'h5C) begin
            failures++;
            $display("FAIL coll_same_addr: got %h expected 5c", rx_buf[1]);
        end
        checks++;
        spi_write_collide(5'd21, 8'h96, 5'd22, 8'h69, early, seen);
        model[21] = 8'h96;
        model[22] = 8'h69;
        tx_buf[0] = {5'd21, 3'b000};
        spi_txn(2);
        if (rx_buf[1] !== 8'h96) begin
            failures++;
            $display("FAIL coll_diff_spi: got %h expected 96", rx_buf[1]);
        end
        checks++;
        tx_buf[0] = {5'd22, 3'b000};
        spi_txn(2);
        if (rx_buf[1] !== 8'h69) begin
            failures++;
            $display("FAIL coll_diff_loc: got %h expected 69", rx_buf[1]);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic        is_wr;
        int          n;
        logic [12:0] exp_wr [$];
        logic [4:0]  exp_rd [$];
        logic [7:0]  exp_data [4];
        for (int t = 0; t < 24; t++) begin
            half = $urandom_range(4, 10);
            if ($urandom_range(0, 3) == 0) loc_write(5'($urandom_range(0, 31)), 8'($urandom));
            a         = 5'($urandom_range(0, 31));
            is_wr     = 1'($urandom_range(0, 1));
            n         = $urandom_range(1, 3);
            status_in = 8'($urandom);
            tx_buf[0] = {a, 1'($urandom_range(0, 1)), is_wr, 1'($urandom_range(0, 1))};
            exp_wr.delete();
            exp_rd.delete();
            for (int k = 1; k <= n; k++) begin
                tx_buf[k] = 8'($urandom);
                if (is_wr) begin
                    exp_wr.push_back({a, tx_buf[k]});
                    if (!RO_MASK[a]) model[a] = tx_buf[k];
                end else begin
                    exp_rd.push_back(a);
                    exp_data[k] = model[a];
                end
            end
            wr_q.delete();
            rd_q.delete();
            spi_txn(n + 1);
            if (rx_buf[0] !== status_in) begin
                failures++;
                $display("FAIL rand%0d_status: got %h expected %h", t, rx_buf[0], status_in);
            end
            checks++;
            if (!is_wr) begin
                for (int k = 1; k <= n; k++) begin
                    if (rx_buf[k] !== exp_data[k]) begin
                        failures++;
                        $display("FAIL rand%0d_rd%0d: got %h expected %h", t, k, rx_buf[k], exp_data[k]);
                    end
                    checks++;
                end
            end
            if (wr_q != exp_wr || rd_q != exp_rd) begin
                failures++;
                $display("FAIL rand%0d_pulses: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         t, wr_q.size(), rd_q.size(), exp_wr.size(), exp_rd.size());
            end
            checks++;
        end
    endtask

    task automatic test_readback_all();
        half = 4;
        for (int a = 0; a < 32; a++) begin
            tx_buf[0] = {a[4:0], 3'b000};
            tx_buf[1] = 8'h00;
            spi_txn(2);
            if (rx_buf[1] !== model[a]) begin
                failures++;
                $display("FAIL readback_%0d: got %h expected %h", a, rx_buf[1], model[a]);
            end
            checks++;
        end
    endtask

    initial begin
        n_rst_in    = 1'b0;
        sclk_in     = 1'b0;
        n_ss_in     = 1'b1;
        mosi_in     = 1'b0;
        status_in   = 8'h00;
        loc_we_in   = 1'b0;
        loc_addr_in = 5'd0;
        loc_data_in = 8'h00;
        sel_ok      = 1'b1;
        for (int a = 0; a < 32; a++) model[a] = 8'h00;

        test_reset();
        test_read_basic();
        test_write_basic();
        test_multi_byte();
        test_read_only();
        test_abort();
        test_reset_mid_rd();
        test_collision();
        test_random();
        test_readback_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max3421_spi_responder.md
Name: max3421_spi_responder

Overview:
- SPI responder modelling the MAX3421E register interface: the far end of the SPI link driven by usb_controller.
- Decodes the MAX3421E command byte, returns a status byte, and serves reads and writes to a 32 x 8 register file.
- Runs oversampled on the system clock.
- Used as the on-chip stand-in for the USB chip in loopback builds and as the bring-up target for usb_controller on pmoda.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk_in / n_ss_in / mosi_in (min 2).
- RO_MASK, 32'h0000_0000, bit i = 1 makes register i read-only over SPI.

Ports:
- clk_in  input  1  system clock; must be at least 8x SCLK.
- n_rst_in  input  1  asynchronous, active-low reset.
- sclk_in  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- n_ss_in  input  1  slave select, active low.
- mosi_in  input  1  serial data from the initiator, MSB first.
- miso_out  output  1  serial data to the initiator, MSB first.
- miso_oe_out  output  1  high while selected; drives the tristate enable.
- status_in  input  8  status byte returned during the command byte.
- loc_we_in  input  1  local register write strobe.
- loc_addr_in  input  5  local write address.
- loc_data_in  input  8  local write data.
- wr_valid_out  output  1  1-cycle pulse: SPI write committed.
- wr_addr_out  output  5  address of the committed write.
- wr_data_out  output  8  data of the committed write.
- rd_valid_out  output  1  1-cycle pulse: SPI read byte completed (FIFO-pop hook).
- rd_addr_out  output  5  address of the completed read.
- busy_out  output  1  high while the FSM is not in IDLE.

Behaviour:
- Async reset (n_rst_in=0) clears:
  - all outputs to 0; miso_out=0, miso_oe_out=0;
  - register file to 0, FSM to IDLE, bit counter to 0;
  - armed flag to 0.
- Synchronization and edge detection:
  - inputs pass through SYNC_STAGES flops;
  - rise and fall of the synchronized sclk are each a 1-cycle strobe;
  - input-to-action latency is SYNC_STAGES+1 clk.
- Armed flag:
  - set when synchronized n_ss is seen high;
  - a select already low at reset release is ignored until n_ss goes high.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE -> CMD on n_ss fall while armed. Same cycle: load shift_out = status_in, drive miso_out = status_in[7], miso_oe_out=1, bit counter = 0.
  - CMD: shift MOSI in on each rise; present the next status bit on each fall.
  - After the 8th rise, cmd = {addr[7:3], bit2 ignored, dir[1], ackstat[0]}; latch addr. dir=1 -> WR. dir=0 -> RD, loading shift_out = reg[addr] in the same cycle.
  - WR: after each 8th rise, commit the byte: reg[addr] <= byte unless RO_MASK[addr]; pulse wr_valid_out the cycle after the rise (also when RO, data not stored). Stay in WR; the address does not auto-increment.
  - RD: present the MSB on the first fall after the command byte. After each 8th rise, pulse rd_valid_out and reload shift_out = reg[addr] (a multi-byte read re-reads the same register).
  - Any state -> IDLE on n_ss rise, same cycle: miso_oe_out=0, miso_out=0, partial byte discarded with no pulse.
- ackstat is captured but has no effect beyond the latch.
- Collisions:
  - SPI commit and loc_we_in to the same address in the same cycle: SPI wins.
  - Different addresses: both take effect.
- Local writes are honoured regardless of RO_MASK.
- Out-of-spec SCLK (half-period < SYNC_STAGES+2 clk): behaviour undefined; not checked.

Decomposition:
- Package usb_spi_pkg holds:
  - typedef spi_state_t {IDLE, CMD, WR, RD};
  - CMD_ADDR_MSB=7, CMD_ADDR_LSB=3, CMD_DIR_BIT=1, CMD_ACK_BIT=0, REG_ADDR_W=5, NUM_REGS=32;
  - MAX3421E register address constants (e.g. REG_USBCTL=15, REG_PINCTL=17, REG_REVISION=18), shared with usb_controller.
- Sub-module: spi_input_sync (per-bit SYNC_STAGES flop chain plus rise/fall detect), instantiated once per synchronized input.

Test Plan:
- Reset, then locally write 8'h13 to address 18; SPI read cmd 8'h90 with status_in=8'hA5 -> MISO returns A5 then 13; one rd_valid_out pulse with rd_addr_out=18.
- SPI write cmd 8'h7A, data 8'h3C -> reg[15]=3C; one wr_valid_out pulse with wr_addr_out=15, wr_data_out=3C; subsequent read cmd 8'h78 returns 3C.
- Write cmd for address 17 followed by data 11, 22, 33 in one select -> three wr_valid_out pulses, reg[17]=33.
- With RO_MASK bit 18 set: SPI write 8'hFF to address 18 -> wr_valid_out pulses, reg[18] unchanged.
- n_ss rises after 4 data bits of a write -> no wr_valid_out, register unchanged, miso_oe_out=0 the same cycle, busy_out=0; a later full transaction succeeds.
- Assert n_rst_in mid-RD with n_ss held low -> outputs 0. After release, SCLK toggling is ignored until n_ss goes high then low again. SPI write and loc_we_in to the same address in the same cycle -> SPI data stored.
